// File: rtl/lcd_glyph_sequencer.sv
// Renders a row of font codes through the external glyph decoder and streams each
// 16x16 bitmap to the graphic LCD write port as 32 page/column-addressed bytes.
module lcd_glyph_sequencer #(
  parameter int N_CHARS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [6*N_CHARS-1:0]   chars,
  output logic [5:0]             bcd,
  input  logic [255:0]           mark,
  output logic                   lcd_valid,
  input  logic                   lcd_ready,
  output logic [7:0]             lcd_data,
  output logic [2:0]             lcd_page,
  output logic [6:0]             lcd_col,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHARS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state;
  logic [6*N_CHARS-1:0] chars_q;
  logic [IDX_W-1:0]     char_idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic [4:0]           byte_idx;
  logic [4:0]           k_nxt;
  logic [4:0]           slot;
  logic [255:0]         glyph;

  assign idx_nxt = char_idx + 1'b1;
  assign k_nxt   = byte_idx + 5'd1;
  assign slot    = 5'(char_idx);

  // Eight glyphs per text row; each text row spans two LCD pages.
  function automatic logic [2:0] page_of(input logic [4:0] s, input logic [4:0] k);
    return {s[4:3], k[4]};
  endfunction

  function automatic logic [6:0] col_of(input logic [4:0] s, input logic [4:0] k);
    return {s[2:0], k[3:0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      chars_q   <= '0;
      char_idx  <= '0;
      byte_idx  <= '0;
      glyph     <= '0;
      bcd       <= '0;
      lcd_valid <= 1'b0;
      lcd_data  <= '0;
      lcd_page  <= '0;
      lcd_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            chars_q  <= chars;
            char_idx <= '0;
            bcd      <= chars[5:0];
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          // The decoder has had a full cycle to settle on bcd.
          glyph     <= mark;
          byte_idx  <= '0;
          lcd_valid <= 1'b1;
          lcd_data  <= mark[7:0];
          lcd_page  <= page_of(slot, 5'd0);
          lcd_col   <= col_of(slot, 5'd0);
          state     <= S_SEND;
        end
        S_SEND: begin
          if (lcd_ready) begin
            if (byte_idx != 5'd31) begin
              byte_idx <= k_nxt;
              lcd_data <= glyph[8*int'(k_nxt) +: 8];
              lcd_page <= page_of(slot, k_nxt);
              lcd_col  <= col_of(slot, k_nxt);
            end else begin
              lcd_valid <= 1'b0;
              if (char_idx != LAST_IDX) begin
                char_idx <= idx_nxt;
                bcd      <= chars_q[6*int'(idx_nxt) +: 6];
                state    <= S_LOAD;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end
            end
          end
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
